// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    // One-hot result encoding, bit order {gt, eq, lt}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/cmp_slice_2bit.sv
// Combinational 2-bit magnitude comparator slice.
module cmp_slice_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle WIDTH-bit magnitude comparator, one 2-bit digit per cycle, MSB first.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands.
module serial_mag_compare
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    cmp_state_t       r_state;
    cmp_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_flags;

    logic [WIDTH-1:0] w_a_cap;
    logic [WIDTH-1:0] w_b_cap;
    logic [1:0]       w_a_dig;
    logic [1:0]       w_b_dig;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic             w_last;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_a_cap = a_in ^ SIGN_FLIP;
    assign w_b_cap = b_in ^ SIGN_FLIP;
`else
    assign w_a_cap = a_in;
    assign w_b_cap = b_in;
`endif

    assign w_a_dig = r_a[{r_idx, 1'b0} +: 2];
    assign w_b_dig = r_b[{r_idx, 1'b0} +: 2];
    assign w_last  = (r_idx == '0);

    cmp_slice_2bit u_slice (
        .i_a  (w_a_dig),
        .i_b  (w_b_dig),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_valid)               w_state_next = ST_RUN;
            ST_RUN:  if (!w_eq || w_last)           w_state_next = ST_DONE;
            ST_DONE: if (res_ready)                 w_state_next = ST_IDLE;
            default:                                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a     <= w_a_cap;
                        r_b     <= w_b_cap;
                        r_idx   <= IDX_W'(DIGITS - 1);
                        r_flags <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_gt) begin
                        r_flags <= RES_GT;
                    end else if (w_lt) begin
                        r_flags <= RES_LT;
                    end else if (w_last) begin
                        r_flags <= RES_EQ;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign a_gt_b      = r_flags[2];
    assign a_eq_b      = r_flags[1];
    assign a_lt_b      = r_flags[0];

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare (WIDTH=8), directed plus random vectors.
module tb_serial_mag_compare;

    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    serial_mag_compare #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .a_gt_b      (a_gt_b),
        .a_eq_b      (a_eq_b),
        .a_lt_b      (a_lt_b),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: relation from integer comparison, {gt,eq,lt}
    function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        if ($signed(a) < $signed(b)) return 3'b001;
`else
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
`endif
        return 3'b010;
    endfunction

    // Reference: edges from accept to res_valid = position of first unequal base-4 digit + 1
    function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int unsigned av = a;
        int unsigned bv = b;
        int unsigned scale = 1 << (WIDTH - 2);
        for (int d = 0; d < DIGITS; d++) begin
            if (((av / scale) % 4) != ((bv / scale) % 4)) return d + 1;
            scale = scale / 4;
        end
        return DIGITS;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int waited = 0;
        while (!start_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("start_ready_wait", start_ready, 1'b1);
        a_in        = a;
        b_in        = b;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a_in        = $urandom;
        b_in        = $urandom;
    endtask

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat = 0;
        while (!res_valid && lat < 20) begin
            check({tag, "_busy"}, busy, 1'b1);
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, ref_latency(a, b));
        check({tag, "_flags"}, {a_gt_b, a_eq_b, a_lt_b}, ref_flags(a, b));
        check({tag, "_sready_done"}, start_ready, 1'b0);
    endtask

    task automatic release_result(input string tag, input logic [2:0] exp_flags);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_rvalid_drop"}, res_valid, 1'b0);
        check({tag, "_idle_ready"}, start_ready, 1'b1);
        check({tag, "_flags_held"}, {a_gt_b, a_eq_b, a_lt_b}, exp_flags);
    endtask

    task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        accept(a, b);
        wait_result(tag, a, b);
        release_result(tag, ref_flags(a, b));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst = 1'b1;
        tick();
        tick();
        check("rst_outputs", {start_ready, res_valid, a_gt_b, a_eq_b, a_lt_b, busy}, 6'b100000);
        rst = 1'b0;
        tick();

        run_cmp("eq_5a", 8'h5A, 8'h5A);
        run_cmp("gt_c0", 8'hC0, 8'h3F);
        run_cmp("lt_12", 8'h12, 8'h13);
        run_cmp("sign_80", 8'h80, 8'h01);

        // Backpressure: result held while start_valid pulses with other operands
        accept(8'h40, 8'h80);
        wait_result("bp", 8'h40, 8'h80);
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0];
            a_in        = 8'hFF;
            b_in        = 8'h00;
            tick();
            check("bp_flags", {a_gt_b, a_eq_b, a_lt_b}, ref_flags(8'h40, 8'h80));
            check("bp_sready", start_ready, 1'b0);
            check("bp_rvalid", res_valid, 1'b1);
        end
        start_valid = 1'b0;
        release_result("bp", ref_flags(8'h40, 8'h80));

        // Reset after two RUN cycles
        accept(8'h00, 8'h01);
        tick();
        check("abort_mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {start_ready, res_valid, a_gt_b, a_eq_b, a_lt_b, busy}, 6'b100000);
        run_cmp("after_abort", 8'hFF, 8'hFE);

        // Back-to-back minimum turnaround
        run_cmp("b2b_a", 8'h01, 8'h00);
        run_cmp("b2b_b", 8'h00, 8'h00);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 3 == 0) ? (ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0))) : WIDTH'($urandom);
            if (i % 7 == 0) rb = ra;
            run_cmp("rand", ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_mag_compare.md
Name: serial_mag_compare

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands.
- Sequences one shared 2-bit comparator slice over the operands, one digit per cycle, MSB digit first.
- Terminates early at the first unequal digit.
- Valid/ready on both the command and result sides, so it drops into COA datapath labs wherever a wide compare is needed without a wide combinational comparator.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2.
- DIGITS, WIDTH/2, derived localparam, not overridable. Number of 2-bit digits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_valid  input  1  command valid
- start_ready  output  1  block can accept a command
- a_in  input  WIDTH  operand A, sampled on accept
- b_in  input  WIDTH  operand B, sampled on accept
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- a_gt_b  output  1  result: A > B
- a_eq_b  output  1  result: A == B
- a_lt_b  output  1  result: A < B
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: FSM=IDLE, start_ready=1, res_valid=0, a_gt_b=a_eq_b=a_lt_b=0, busy=0, idx=0, operand regs=0.
- FSM states:
  - IDLE: start_ready=1. Accept when start_valid && start_ready at a clock edge. On accept: capture a_in/b_in into a_q/b_q, idx=DIGITS-1, clear result flags, go to RUN.
  - RUN: slice compares a_q[2*idx+1:2*idx] vs b_q[2*idx+1:2*idx] combinationally.
    - Slice gt or lt: register the one-hot flags, go to DONE.
    - Slice eq and idx==0: set a_eq_b=1, go to DONE.
    - Otherwise: idx decrements by 1, stay in RUN.
  - DONE: res_valid=1, flags held stable. On res_valid && res_ready, go to IDLE; res_valid drops the next cycle. Flags keep their value until the next accept.
- start_ready is 0 in RUN and DONE. start_valid there is ignored; no queuing.
- Latency, counting from the accepting edge E0: res_valid rises after edge E0+k+1, where k is the 0-based index from the MSB of the first unequal digit. Equal operands give DIGITS edges, which is also the maximum.
- Result flags are registered and exactly one-hot whenever res_valid=1.
- Minimum turnaround: a new command can be accepted on the edge after result handshake completes, because IDLE asserts start_ready=1.
- Reset mid-operation (RUN or DONE) aborts the compare. All outputs return to reset values on that edge; no partial result is ever presented.
- idx width is clog2(DIGITS) with a minimum of 1. WIDTH=2 runs exactly one RUN cycle.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. At capture, bit WIDTH-1 of both a_in and b_in is inverted before storing, which maps signed order onto unsigned order. Sequencing and latency are unchanged.
- Undefined: unsigned comparison with no capture-path logic.

Decomposition:
- Package serial_cmp_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - 3-bit result encoding constants (GT=3'b100, EQ=3'b010, LT=3'b001)
- One sub-module: cmp_slice_2bit.
  - Purely combinational 2-bit comparator.
  - Outputs gt/eq/lt.
  - Instantiated once and muxed by idx.
- FSM, counter and operand registers live in the top module.

Test Plan (WIDTH=8):
- A=8'h5A, B=8'h5A -> a_eq_b=1, gt=lt=0; res_valid rises 4 edges after accept.
- A=8'hC0, B=8'h3F -> a_gt_b=1; res_valid after 1 edge (MSB digit 11 vs 00).
- A=8'h12, B=8'h13 -> a_lt_b=1; res_valid after 4 edges; busy=1 throughout.
- Backpressure on A=8'h40, B=8'h80:
  - Hold res_ready=0 for 5 cycles while pulsing start_valid. Flags must stay a_lt_b=1, start_ready must stay 0, no new capture may occur.
  - Then raise res_ready: IDLE on the next edge.
- Reset mid-operation on A=8'h00, B=8'h01:
  - Assert rst for 1 cycle after 2 RUN cycles. All outputs return to 0 and start_ready=1.
  - A following A=8'hFF, B=8'hFE must return a_gt_b=1 after 4 edges.
- Signedness on A=8'h80, B=8'h01:
  - With SERIAL_CMP_SIGNED_EN defined -> a_lt_b=1.
  - Without it -> a_gt_b=1.
  - Latency is 1 edge in both builds.
